// File: rtl/instr_packer_if.sv
// Request channel of the instruction packer: handshake plus the decoded
// instruction fields that get packed into one 32-bit word.
interface instr_packer_if;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    modport master (
        output in_valid, in_last, opcode, funct3, funct7, rd, rs1, rs2, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, opcode, funct3, funct7, rd, rs1, rs2, imm,
        output in_ready
    );
endinterface

// File: rtl/instr_packer.sv
// Packs RV32 instruction fields into machine words and streams them into an
// instruction memory, one word per cycle, until the session ends.
module instr_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    instr_packer_if.slave              req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       done,
    output logic                       err,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     word_count
);
    localparam int WCW = $clog2(DEPTH) + 1;

    typedef enum logic {LOAD, DONE} state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t          state_reg;
    logic [31:0]     enc_word;
    logic            enc_legal;
    logic            accept;
    logic [WCW-1:0]  word_count_next;
    logic [31:0]     word_offset;

    assign req.in_ready    = (state_reg == LOAD) && !clear;
    assign accept          = req.in_valid && req.in_ready;
    assign done            = (state_reg == DONE);
    assign word_count_next = word_count + 1'b1;
    assign word_offset     = 32'(word_count) << 2;

    // Immediates must be representable in the encoded field: upper bits are a
    // pure sign extension, and branch offsets are halfword aligned.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (req.opcode)
            OP_LOAD, OP_IMM: begin
                enc_word  = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                enc_legal = (&req.imm[31:11]) || !(|req.imm[31:11]);
            end
            OP_STORE: begin
                enc_word  = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                             req.imm[4:0], req.opcode};
                enc_legal = (&req.imm[31:11]) || !(|req.imm[31:11]);
            end
            OP_BRANCH: begin
                enc_word  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                             req.imm[4:1], req.imm[11], req.opcode};
                enc_legal = !req.imm[0] && ((&req.imm[31:12]) || !(|req.imm[31:12]));
            end
            OP_REG: begin
                enc_word  = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= LOAD;
            word_count <= '0;
            err_count  <= 8'd0;
            mem_we     <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'h0;
        end else if (clear) begin
            state_reg  <= LOAD;
            word_count <= '0;
            mem_we     <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (accept) begin
                if (enc_legal) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= BASE_ADDR + word_offset;
                    mem_wdata  <= enc_word;
                    word_count <= word_count_next;
                    if (req.in_last || (word_count_next == WCW'(DEPTH)))
                        state_reg <= DONE;
                end else begin
                    err <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                    if (req.in_last)
                        state_reg <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer with a small DEPTH so the fill limit is reachable.
module tb_instr_packer;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic [7:0]  err_count;
    logic [$clog2(DEP):0] word_count;

    int checks = 0;
    int errors = 0;

    instr_packer_if bus ();

    instr_packer #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req        (bus.slave),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .done       (done),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                         input logic [31:0] imm_i, input logic last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rd       = rd_i;
        bus.rs1      = rs1_i;
        bus.rs2      = rs2_i;
        bus.imm      = imm_i;
        $display("req op=%b f3=%0d rd=%0d rs1=%0d rs2=%0d imm=%h last=%0b",
                 op, f3, rd_i, rs1_i, rs2_i, imm_i, last);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        idle();
        drive(7'h0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        idle();
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_ec", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // addi x1, x2, -1
        drive(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        idle();
        check("i_we", 32'(mem_we), 32'd1);
        check("i_addr", mem_addr, BASE);
        check("i_wdata", mem_wdata, 32'hFFF1_0093);
        check("i_wc", 32'(word_count), 32'd1);
        tick();
        check("idle_we", 32'(mem_we), 32'd0);
        check("hold_addr", mem_addr, BASE);
        check("hold_wdata", mem_wdata, 32'hFFF1_0093);

        // Three illegal requests back to back
        drive(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0);
        tick();
        check("ill_i_err", 32'(err), 32'd1);
        check("ill_i_we", 32'(mem_we), 32'd0);
        check("ill_i_ec", 32'(err_count), 32'd1);
        drive(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        tick();
        check("ill_b_err", 32'(err), 32'd1);
        check("ill_b_ec", 32'(err_count), 32'd2);
        drive(7'b1111111, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0);
        tick();
        idle();
        check("ill_op_err", 32'(err), 32'd1);
        check("ill_op_we", 32'(mem_we), 32'd0);
        check("ill_ec", 32'(err_count), 32'd3);
        check("ill_wc", 32'(word_count), 32'd1);
        tick();
        check("ill_err_clr", 32'(err), 32'd0);

        // beq x1, x2, -4 as the final word
        drive(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1);
        tick();
        check("b_we", 32'(mem_we), 32'd1);
        check("b_addr", mem_addr, BASE + 32'd4);
        check("b_wdata", mem_wdata, 32'hFE20_8EE3);
        check("b_done", 32'(done), 32'd1);
        check("b_ready", 32'(bus.in_ready), 32'd0);
        tick();
        idle();
        check("done_we", 32'(mem_we), 32'd0);
        check("done_hold", 32'(done), 32'd1);
        check("done_wc", 32'(word_count), 32'd2);

        clear = 1'b1;
        #1;
        check("clear_ready", 32'(bus.in_ready), 32'd0);
        tick();
        clear = 1'b0;
        #1;
        check("clr_done", 32'(done), 32'd0);
        check("clr_wc", 32'(word_count), 32'd0);
        check("clr_ready", 32'(bus.in_ready), 32'd1);
        check("clr_ec", 32'(err_count), 32'd3);

        // Fill to DEPTH with mixed legal types
        drive(7'b0110011, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("f0_addr", mem_addr, BASE);
        check("f0_wdata", mem_wdata, 32'h0020_81B3);
        drive(7'b0100011, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
        tick();
        check("f1_we", 32'(mem_we), 32'd1);
        check("f1_addr", mem_addr, BASE + 32'd4);
        check("f1_wdata", mem_wdata, 32'hFE20_AC23);
        drive(7'b0000011, 3'd2, 7'h00, 5'd5, 5'd1, 5'd0, 32'd16, 1'b0);
        tick();
        check("f2_addr", mem_addr, BASE + 32'd8);
        check("f2_wdata", mem_wdata, 32'h0100_A283);
        check("f2_done", 32'(done), 32'd0);
        drive(7'b0110011, 3'd0, 7'h20, 5'd4, 5'd1, 5'd2, 32'h1234_5678, 1'b0);
        tick();
        check("f3_addr", mem_addr, BASE + 32'd12);
        check("f3_wdata", mem_wdata, 32'h4020_8233);
        check("f3_wc", 32'(word_count), 32'd4);
        check("f3_done", 32'(done), 32'd1);
        drive(7'b0110011, 3'd0, 7'h00, 5'd6, 5'd1, 5'd2, 32'h0, 1'b0);
        #1;
        check("f4_ready", 32'(bus.in_ready), 32'd0);
        tick();
        idle();
        check("f4_we", 32'(mem_we), 32'd0);
        check("f4_wc", 32'(word_count), 32'd4);

        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Clear in the cycle after an acceptance
        drive(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        check("pre_clr_we", 32'(mem_we), 32'd1);
        clear = 1'b1;
        #1;
        check("clr_blocks_ready", 32'(bus.in_ready), 32'd0);
        tick();
        clear = 1'b0;
        check("sup_we", 32'(mem_we), 32'd0);
        check("sup_wc", 32'(word_count), 32'd0);
        check("sup_err", 32'(err), 32'd0);
        tick();
        idle();
        check("restart_addr", mem_addr, BASE);
        check("restart_wc", 32'(word_count), 32'd1);

        // Asynchronous reset mid-stream
        drive(7'b0010011, 3'd0, 7'd0, 5'd7, 5'd2, 5'd0, 32'd5, 1'b0);
        tick();
        check("mid_we", 32'(mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_wc", 32'(word_count), 32'd0);
        check("arst_ec", 32'(err_count), 32'd0);
        check("arst_addr", mem_addr, BASE);
        check("arst_wdata", mem_wdata, 32'h0);
        check("arst_done", 32'(done), 32'd0);
        idle();
        tick();
        rst = 1'b0;

        // err_count saturation
        drive(7'b1111111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 260; i++) tick();
        idle();
        check("sat_ec", 32'(err_count), 32'd255);
        check("sat_wc", 32'(word_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 SHALL have parameter DEPTH, default 256, maximum number of words written per load session (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous session restart.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_last, input, 1, request is the final word of the session.
REQ-008 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-009 SHALL have ports opcode[6:0], funct3[2:0], funct7[6:0], rd[4:0], rs1[4:0] and rs2[4:0], all inputs, carrying the instruction fields.
REQ-010 SHALL have port imm, input, 32, signed immediate value (byte offset for B-type).
REQ-011 SHALL have port mem_we, output, 1, instruction-memory write strobe.
REQ-012 SHALL have port mem_addr, output, 32, write byte address.
REQ-013 SHALL have port mem_wdata, output, 32, encoded instruction word.
REQ-014 SHALL have port done, output, 1, session complete.
REQ-015 SHALL have port err, output, 1, one-cycle pulse on a rejected request.
REQ-016 SHALL have port err_count, output, 8, saturating count of rejected requests.
REQ-017 SHALL have port word_count, output, log2(DEPTH)+1 bits, number of words written this session.

Function
REQ-018 SHALL implement an FSM with states LOAD and DONE.
REQ-019 in_ready SHALL be 1 only when the state is LOAD and clear=0.
REQ-020 Encoding for I-type (opcodes 0000011 and 0010011) SHALL be {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 Encoding for S-type (0100011) SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 Encoding for B-type (1100011) SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 Encoding for R-type (0110011) SHALL be {funct7, rs2, rs1, funct3, rd, opcode}; imm is ignored.
REQ-024 I-type and S-type requests SHALL be legal only when imm[31:11] are all equal.
REQ-025 B-type requests SHALL be legal only when imm[0]=0 and imm[31:12] are all equal.
REQ-026 Any other opcode SHALL be illegal.
REQ-027 An accepted legal request SHALL drive mem_we=1 in the next cycle, with mem_addr = BASE_ADDR + 4*word_count (pre-increment value) and mem_wdata set to the encoded word; word_count SHALL increment by 1 in that same cycle.
REQ-028 An accepted illegal request SHALL drive err=1 in the next cycle with mem_we=0, and SHALL leave word_count and the address unchanged.
REQ-029 err_count SHALL increment on each err pulse and SHALL saturate at 255.
REQ-030 Throughput SHALL be one request per cycle, with no bubbles in LOAD.
REQ-031 The FSM SHALL move LOAD->DONE on acceptance of a request with in_last=1, whether that request is legal or illegal.
REQ-032 The FSM SHALL move LOAD->DONE on acceptance of the legal request that brings word_count to DEPTH.
REQ-033 done SHALL be 1 in every cycle the state is DONE.
REQ-034 mem_we and err SHALL be 0 in every cycle not immediately following an acceptance.
REQ-035 The write or err pulse from the final accepted request SHALL still issue in the first DONE cycle.
REQ-036 clear=1 in any state SHALL, at the next edge: set the state to LOAD, set word_count to 0, and cancel any pending write or err pulse (mem_we=0, err=0).
REQ-037 clear=1 SHALL leave err_count unchanged.
REQ-038 Acceptance SHALL be impossible in the cycle clear=1.
REQ-039 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-040 Asynchronous rst=1 SHALL immediately force: state LOAD; word_count=0; err_count=0; mem_we=0; err=0; done=0; mem_addr=BASE_ADDR; mem_wdata=0.
REQ-041 rst asserted mid-session SHALL discard any pending write.
REQ-042 After rst is released, in_ready SHALL be 1 in the first cycle if clear=0.

Verification
REQ-043 I-type: opcode=0010011, rd=1, rs1=2, funct3=0, imm=-1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=32'hFFF1_0093.
REQ-044 B-type: opcode=1100011, rs1=1, rs2=2, funct3=0, imm=-4, in_last=1 -> mem_wdata=32'hFE20_8EE3; done=1 from the following cycle; in_ready=0.
REQ-045 Illegal requests: I-type with imm=2048, then B-type with imm=3, then opcode=1111111 -> three err pulses; err_count=3; no mem_we; word_count unchanged.
REQ-046 Fill with DEPTH=4: four back-to-back legal requests -> addresses 0, 4, 8, 12; word_count=4; DONE entered; a fifth request is not accepted.
REQ-047 Clear: clear asserted in DONE -> LOAD next cycle; word_count=0; next write goes to BASE_ADDR. Clear asserted the cycle after an acceptance -> that write is suppressed.
REQ-048 Reset: rst asserted mid-stream -> all outputs return to their reset values asynchronously, and err_count=0.
